// File: rtl/counter_8_monitor.sv
// Receive-side checker for the mod-MOD counter interface: verifies count steps and carry,
// reports lock, fault pulses, a saturating fault count and stall.
module counter_8_monitor #(
    parameter int MOD     = 8,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       CP,
    input  logic       _CLR,
    input  logic       M,
    input  logic       Qa,
    input  logic       Qb,
    input  logic       Qc,
    input  logic       Qd,
    input  logic       _Qcc,
    output logic       LOCK,
    output logic       ERR,
    output logic [7:0] ERR_CNT,
    output logic       STALL,
    output logic [3:0] CUR
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   good, good_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [3:0]      q_r, q_d, exp_q;
    logic            m_r, m_d, cc_r;
    logic            chg, mode_chg, carry_low, carry_bad, range_bad, step_bad;
    logic            fault, stall_hit;
    logic            lock_nxt, err_nxt, stall_nxt;
    logic [7:0]      cnt_nxt;

    // q_d is the previous registered sample and serves as the step reference
    always_comb begin
        chg       = (q_r != q_d);
        mode_chg  = (m_r != m_d);
        if (m_r)
            exp_q = (q_d == 4'(MOD - 1)) ? 4'd0 : q_d + 4'd1;
        else
            exp_q = (q_d == 4'd0) ? 4'(MOD - 1) : q_d - 4'd1;
        carry_low = m_r ? (q_r == 4'(MOD - 1)) : (q_r == 4'd0);
        carry_bad = (cc_r == carry_low);
        range_bad = ({1'b0, q_r} >= 5'(MOD));
        step_bad  = chg && (q_r != exp_q);
        fault     = (state != HUNT) && !mode_chg && (carry_bad || range_bad || step_bad);
        if (chg)
            timer_nxt = '0;
        else if (timer == TW'(TIMEOUT))
            timer_nxt = timer;
        else
            timer_nxt = timer + TW'(1);
        stall_hit = (timer_nxt == TW'(TIMEOUT));
    end

    always_ff @(posedge CP or negedge _CLR) begin
        if (!_CLR) begin
            state <= HUNT;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        case (state)
            HUNT: begin
                if (chg) begin
                    state_nxt = VERIFY;
                    good_nxt  = '0;
                end
            end
            VERIFY: begin
                if (mode_chg || fault) begin
                    state_nxt = HUNT;
                end else if (chg) begin
                    good_nxt = good + GW'(1);
                    if (good_nxt == GW'(LOCK_N))
                        state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (mode_chg || fault)
                    state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
        if (stall_hit)
            state_nxt = HUNT;
    end

    always_comb begin
        lock_nxt = (state_nxt == LOCKED);
        err_nxt  = fault;
        cnt_nxt  = (fault && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
        if (stall_hit)
            stall_nxt = 1'b1;
        else if (chg)
            stall_nxt = 1'b0;
        else
            stall_nxt = STALL;
    end

    always_ff @(posedge CP or negedge _CLR) begin
        if (!_CLR) begin
            q_r     <= '0;
            q_d     <= '0;
            m_r     <= 1'b1;
            m_d     <= 1'b1;
            cc_r    <= 1'b1;
            timer   <= '0;
            LOCK    <= 1'b0;
            ERR     <= 1'b0;
            ERR_CNT <= '0;
            STALL   <= 1'b0;
        end else begin
            q_r     <= {Qd, Qc, Qb, Qa};
            q_d     <= q_r;
            m_r     <= M;
            m_d     <= m_r;
            cc_r    <= _Qcc;
            timer   <= timer_nxt;
            LOCK    <= lock_nxt;
            ERR     <= err_nxt;
            ERR_CNT <= cnt_nxt;
            STALL   <= stall_nxt;
        end
    end

    assign CUR = q_r;

endmodule

// File: tb/tb_counter_8_monitor.sv
// Bench for counter_8_monitor: directed scenarios plus randomized counter traffic,
// checked every cycle against a behavioural model of the monitor rules.
module tb_counter_8_monitor;

    localparam int MOD     = 8;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 1024;

    logic       clk, clr_n, m_in, qcc_in;
    logic [3:0] q_in;
    logic       lock, err, stall;
    logic [7:0] err_cnt;
    logic [3:0] cur;

    counter_8_monitor #(.MOD(MOD), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)) dut (
        .CP(clk), ._CLR(clr_n), .M(m_in),
        .Qa(q_in[0]), .Qb(q_in[1]), .Qc(q_in[2]), .Qd(q_in[3]), ._Qcc(qcc_in),
        .LOCK(lock), .ERR(err), .ERR_CNT(err_cnt), .STALL(stall), .CUR(cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // model: last two registered samples plus rule-level tracking
    int r_q, d_q, good, e_cnt, since;
    bit r_m, d_m, r_cc, hunting, e_lock, e_err;
    int g_cnt;
    bit g_m;

    function automatic int next_count(int q, bit m);
        if (m) return (q == MOD - 1) ? 0 : ((q + 1) & 15);
        return (q == 0) ? MOD - 1 : q - 1;
    endfunction

    function automatic bit natural_cc(int q, bit m);
        return !(m ? (q == MOD - 1) : (q == 0));
    endfunction

    task automatic model_reset();
        r_q = 0; d_q = 0; r_m = 1; d_m = 1; r_cc = 1;
        hunting = 1; good = 0; e_lock = 0; e_err = 0; e_cnt = 0; since = 0;
    endtask

    task automatic model_edge();
        bit chg, mchg, fault, cc_should_low;
        chg  = (r_q != d_q);
        mchg = (r_m != d_m);
        since = chg ? 0 : ((since < TIMEOUT) ? since + 1 : TIMEOUT);
        cc_should_low = r_m ? (r_q == MOD - 1) : (r_q == 0);
        fault = !hunting && !mchg &&
                ((chg && r_q != next_count(d_q, r_m)) || r_q >= MOD || (r_cc == cc_should_low));
        e_err = fault;
        if (hunting) begin
            if (chg) begin hunting = 0; good = 0; end
        end else if (mchg || fault) begin
            hunting = 1;
        end else if (chg) begin
            good++;
        end
        if (fault && e_cnt < 255) e_cnt++;
        if (since == TIMEOUT) hunting = 1;
        e_lock = !hunting && (good >= LOCK_N);
        d_q = r_q; d_m = r_m;
        r_q = int'(q_in); r_m = m_in; r_cc = qcc_in;
    endtask

    task automatic check();
        n_vec++;
        assert (lock === e_lock) else begin
            n_bad++; $error("FAIL lock observed=%0b expected=%0b t=%0t", lock, e_lock, $time);
        end
        n_vec++;
        assert (err === e_err) else begin
            n_bad++; $error("FAIL err observed=%0b expected=%0b t=%0t", err, e_err, $time);
        end
        n_vec++;
        assert (err_cnt === 8'(e_cnt)) else begin
            n_bad++; $error("FAIL err_cnt observed=%0d expected=%0d t=%0t", err_cnt, e_cnt, $time);
        end
        n_vec++;
        assert (stall === (since == TIMEOUT)) else begin
            n_bad++; $error("FAIL stall observed=%0b expected=%0b t=%0t", stall, since == TIMEOUT, $time);
        end
        n_vec++;
        assert (cur === 4'(r_q)) else begin
            n_bad++; $error("FAIL cur observed=%0d expected=%0d t=%0t", cur, r_q, $time);
        end
    endtask

    task automatic expect_val(string tag, int obs, int req);
        n_vec++;
        assert (obs == req) else begin
            n_bad++; $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!clr_n) model_reset(); else model_edge();
        #1;
        check();
    endtask

    task automatic hold(int n);
        repeat (n) tick();
    endtask

    task automatic drive(int q, bit cc);
        q_in = 4'(q); qcc_in = cc; m_in = g_m;
    endtask

    task automatic step_nat(int n, int period);
        repeat (n) begin
            g_cnt = next_count(g_cnt, g_m);
            drive(g_cnt, natural_cc(g_cnt, g_m));
            hold(period);
        end
    endtask

    task automatic count_until(int target);
        for (int i = 0; i < 2 * MOD && g_cnt != target; i++) step_nat(1, 4);
    endtask

    initial begin
        int q, r;
        bit cc;
        model_reset();
        g_cnt = 0; g_m = 1;
        clr_n = 1'b0;
        drive(0, 1);
        hold(3);
        clr_n = 1'b1;
        hold(4);

        // up count with wraps
        step_nat(12, 4);
        expect_val("up_lock", int'(lock), 1);
        expect_val("up_errcnt", int'(err_cnt), 0);

        // skip 3 -> 5 while locked, then relock
        count_until(3);
        g_cnt = 5; drive(5, natural_cc(5, g_m)); hold(4);
        expect_val("skip_errcnt", int'(err_cnt), 1);
        expect_val("skip_lock", int'(lock), 0);
        step_nat(5, 4);
        expect_val("relock", int'(lock), 1);

        // carry held high at 7, then carry low at 4
        count_until(6);
        g_cnt = 7; drive(7, 1'b1); hold(4);
        expect_val("carry7_errcnt", int'(err_cnt), 2);
        step_nat(6, 4);
        count_until(3);
        g_cnt = 4; drive(4, 1'b0); hold(4);
        expect_val("carry4_errcnt", int'(err_cnt), 3);
        step_nat(6, 4);

        // mode flip while locked, then down count with 0 -> 7 wrap
        g_m = 0; drive(g_cnt, natural_cc(g_cnt, g_m)); hold(4);
        expect_val("flip_lock", int'(lock), 0);
        expect_val("flip_errcnt", int'(err_cnt), 3);
        step_nat(12, 4);
        expect_val("down_lock", int'(lock), 1);

        // freeze at 2 until stall, then release
        count_until(2);
        hold(TIMEOUT + 6);
        expect_val("stall_set", int'(stall), 1);
        step_nat(1, 4);
        expect_val("stall_clear", int'(stall), 0);

        // fault storm to saturate the counter
        g_m = 1;
        for (int i = 0; i < 620; i++) begin
            g_cnt = (2 * i + 2) % MOD;
            drive(g_cnt, natural_cc(g_cnt, g_m));
            hold(2);
        end
        expect_val("saturate", int'(err_cnt), 255);

        // relock, then asynchronous reset between clock edges
        step_nat(6, 4);
        expect_val("prereset_lock", int'(lock), 1);
        #2 clr_n = 1'b0;
        #1;
        expect_val("async_lock", int'(lock), 0);
        expect_val("async_errcnt", int'(err_cnt), 0);
        expect_val("async_cur", int'(cur), 0);
        expect_val("async_stall", int'(stall), 0);
        hold(2);
        clr_n = 1'b1;
        hold(2);

        // randomized traffic with injected faults and mode flips
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) g_m = ~g_m;
            r = $urandom_range(0, 9);
            g_cnt = next_count(g_cnt, g_m);
            q = g_cnt;
            cc = natural_cc(q, g_m);
            case (r)
                0: begin q = next_count(g_cnt, g_m); g_cnt = q; cc = natural_cc(q, g_m); end
                1: cc = ~cc;
                2: q = $urandom_range(MOD, 15);
                default: ;
            endcase
            drive(q, cc);
            hold($urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_8_monitor.md
Name: counter_8_monitor

Overview:
- Receiving end of the mod-8 counter output interface (Qa..Qd, _Qcc, mode M).
- Samples the counter outputs on the undivided clock CP and checks each count transition against the expected up/down sequence.
- Checks the carry output against the current count.
- Reports lock, per-event errors, a saturating error count and stall detection; drives board LEDs and self-test logic.

Parameters:
MOD, 8, counter modulus; legal counts 0..MOD-1 (MOD ≤ 16)
LOCK_N, 4, consecutive good transitions required to assert LOCK
TIMEOUT, 1024, CP cycles without a count change before STALL asserts (≥ 2)

Ports:
CP  input  1  system clock, rising edge
_CLR  input  1  asynchronous active-low reset
M  input  1  counter mode: 1 = count up, 0 = count down
Qa  input  1  count bit 0 (LSB)
Qb  input  1  count bit 1
Qc  input  1  count bit 2
Qd  input  1  count bit 3 (MSB)
_Qcc  input  1  counter carry/borrow, active low
LOCK  output  1  sequence verified
ERR  output  1  one-CP pulse per detected fault
ERR_CNT  output  8  saturating fault count
STALL  output  1  no count change for TIMEOUT cycles
CUR  output  4  last registered count {Qd,Qc,Qb,Qa}

Behaviour:
- One clock (CP); reset is asynchronous and active-low (_CLR).
- Reset (_CLR=0) values: LOCK=0, ERR=0, ERR_CNT=0, STALL=0, CUR=0, state=HUNT, timer=0, good-run=0. Reset applies immediately, including mid-check; no pending error survives it.
- Input stage: M, Q[3:0], _Qcc registered once per CP into q_r, m_r, cc_r.
- Change event: q_r differs from its value one cycle earlier (prev); evaluated in the cycle after registration. Total latency from an input edge to ERR/LOCK is 2 CP cycles.
- Expected next value:
  - m_r=1: prev+1; prev=MOD-1 wraps to 0.
  - m_r=0: prev-1; prev=0 wraps to MOD-1.
  - Arithmetic is 4-bit modulo MOD.
- Carry rule, checked every cycle while not in HUNT:
  - cc_r must be 0 iff (m_r=1 and q_r=MOD-1) or (m_r=0 and q_r=0).
  - Otherwise cc_r must be 1.
- Range rule: q_r ≥ MOD is an error in any state except HUNT.
- State machine:
  - HUNT: on the first change event, prev loads q_r, good-run=0, go to VERIFY. No errors are raised in HUNT.
  - VERIFY: a correct change increments good-run; when good-run reaches LOCK_N, go to LOCKED and set LOCK=1.
  - LOCKED: a correct change keeps LOCKED.
  - Fault in VERIFY or LOCKED (bad step, carry or range): ERR=1 for one cycle, ERR_CNT+1 (saturates at 255), LOCK=0, prev=q_r, go to HUNT.
  - Change of m_r between two samples: go to HUNT, LOCK=0, no error.
- Simultaneous faults in one cycle count once. A carry fault coincident with a bad step counts once.
- Stall timer:
  - Clears on every change event; otherwise increments, saturating.
  - When it reaches TIMEOUT: STALL=1, LOCK=0, state=HUNT, no ERR.
  - STALL clears on the next change event.
- Counter held in clear (Q=0, no change): leads to STALL after TIMEOUT; no error is raised.
- CUR = q_r every cycle.

Test Plan:
- Reset mid-LOCKED: _CLR low at any time → all outputs 0 asynchronously; after release, state HUNT.
- Up count, M=1, counter advances every 4 CP (0,1..7,0,1…), _Qcc low only at 7 → LOCK=1 two CP after the 5th change (1st change locks reference, then 4 good); ERR never asserted through wraps 7→0.
- Down count, M=0, sequence 7,6..0,7, _Qcc low only at 0 → LOCK=1; 0→7 wrap accepted.
- Skip fault while locked, up: force 3→5 → ERR one-cycle pulse, ERR_CNT=1, LOCK=0; relocks after 5 further good changes.
- Carry fault: _Qcc held high at count 7, M=1 → ERR pulse, ERR_CNT increments once. Separately, _Qcc low at count 4 → ERR.
- Mode flip and stall:
  - Switch M 1→0 while locked → LOCK drops, ERR_CNT unchanged.
  - Freeze counter at 2 for 1024 CP → STALL=1 exactly at cycle 1024; next change clears STALL.
- Saturation: inject 300 faults → ERR_CNT=255.
